m_prog_loader: RTL and testbench

- Byte-stream program loader: the writer side of the instruction/data memory that the pipelined processor reads.
- Receives a length-prefixed byte stream over a valid/ready handshake from the host link (UART receiver or VIO).
- Packs bytes into 32-bit little-endian words and issues single-cycle writes to the memory write port.
- Holds the processor in reset until the image is fully written, then releases it.

---
 rtl/m_prog_loader.sv | 160 ++++++++++++++++
 tb/tb_m_prog_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_prog_loader.sv
// m_prog_loader: byte-stream program loader for the processor's instruction/data memory.
// The stream is a 16-bit little-endian word count L followed by L words, each sent as
// four little-endian bytes. Each completed word becomes one single-cycle memory write.
// The processor is held in reset until the whole image has been written.
// Optional feature: define LOADER_CSUM_EN to require an XOR checksum byte after the payload.
module m_prog_loader #(
    parameter int ADDR_W    = 11,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 2048
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic [7:0]        w_din,
    input  logic              w_dvalid,
    output logic              w_dready,
    input  logic              w_reload,
    output logic [ADDR_W-1:0] w_maddr,
    output logic [31:0]       w_mdata,
    output logic              w_mwe,
    output logic              w_prst,
    output logic              w_done,
    output logic              w_err
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef LOADER_CSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_L  = 17'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [15:0] wcnt;
    logic [1:0]  bidx;
    logic [23:0] asm_q;
    logic [15:0] len_new;
    logic        accept;
`ifdef LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    // Only the two terminal states refuse bytes; memory never backpressures.
    always_comb begin
        w_dready = (state != S_DONE) && (state != S_ERR);
    end

    assign accept  = w_dvalid && w_dready;
    assign len_new = {w_din, len[7:0]};

    // Loader FSM: length capture, word assembly, memory writes, completion flags.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state   <= S_LEN0;
            len     <= '0;
            wcnt    <= '0;
            bidx    <= '0;
            asm_q   <= '0;
            w_maddr <= BASE_A;
            w_mdata <= '0;
            w_mwe   <= 1'b0;
            w_prst  <= 1'b1;
            w_done  <= 1'b0;
            w_err   <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum    <= '0;
`endif
        end else begin
            w_mwe <= 1'b0;
            case (state)
                S_LEN0: begin
                    if (accept) begin
                        len[7:0] <= w_din;
                        state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        len[15:8] <= w_din;
                        wcnt      <= '0;
                        bidx      <= '0;
`ifdef LOADER_CSUM_EN
                        csum      <= '0;
`endif
                        if (len_new == 16'd0 || {1'b0, len_new} > MAX_L) begin
                            state <= S_ERR;
                            w_err <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
`ifdef LOADER_CSUM_EN
                        csum <= csum ^ w_din;
`endif
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: asm_q[7:0]   <= w_din;
                            2'd1: asm_q[15:8]  <= w_din;
                            2'd2: asm_q[23:16] <= w_din;
                            default: begin
                                // Fourth byte completes the word: write it next cycle.
                                w_mwe   <= 1'b1;
                                w_mdata <= {w_din, asm_q};
                                w_maddr <= BASE_A + ADDR_W'(wcnt);
                                wcnt    <= wcnt + 16'd1;
                                if (wcnt == len - 16'd1) begin
`ifdef LOADER_CSUM_EN
                                    state  <= S_CSUM;
`else
                                    state  <= S_DONE;
                                    w_done <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        if (w_din == csum) begin
                            state  <= S_DONE;
                            w_done <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            w_err <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (w_reload) begin
                        state  <= S_LEN0;
                        len    <= '0;
                        wcnt   <= '0;
                        bidx   <= '0;
                        w_prst <= 1'b1;
                        w_done <= 1'b0;
                        w_err  <= 1'b0;
                    end else if (state == S_DONE) begin
                        // Released one cycle after the final write lands.
                        w_prst <= 1'b0;
                    end
                end
                default: state <= S_LEN0;
            endcase
        end
    end

endmodule

// File: tb/tb_m_prog_loader.sv
// Scoreboard bench for m_prog_loader: stimulus pushes expected memory writes into a
// queue; a monitor pops and compares on every w_mwe cycle.
module tb_m_prog_loader;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic [7:0]  w_din = 8'h00;
    logic        w_dvalid = 1'b0;
    logic        w_dready;
    logic        w_reload = 1'b0;
    logic [10:0] w_maddr;
    logic [31:0] w_mdata;
    logic        w_mwe;
    logic        w_prst;
    logic        w_done;
    logic        w_err;

    m_prog_loader #(.ADDR_W(11), .BASE_ADDR(0), .MAX_WORDS(2048)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_din(w_din), .w_dvalid(w_dvalid),
        .w_dready(w_dready), .w_reload(w_reload), .w_maddr(w_maddr), .w_mdata(w_mdata),
        .w_mwe(w_mwe), .w_prst(w_prst), .w_done(w_done), .w_err(w_err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] pay_q[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          n_wr   = 0;
    int          gap_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write cycle must match the oldest expected write.
    always @(negedge w_clk) begin
        if (w_rst_n && w_mwe === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", w_maddr, w_mdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(w_maddr), 32'(mon_e.a));
                chk("wr_data", w_mdata, mon_e.d);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, gap_max)) @(negedge w_clk);
        @(negedge w_clk);
        w_din = b;
        w_dvalid = 1'b1;
        n = 0;
        while (w_dready !== 1'b1 && n < 20) begin
            @(negedge w_clk);
            n++;
        end
        if (w_dready !== 1'b1) begin
            n_tot++;
            $display("FAIL dready_timeout: got 0 expected 1");
        end
        @(posedge w_clk);
        #1 w_dvalid = 1'b0;
    endtask

    // Full load of L words; payload from pay_q, random when it runs dry.
    task automatic do_load(input logic [15:0] L, input bit bad_csum);
        logic [31:0] word;
        logic [7:0]  x;
        bit          legal;
        bit          ok;
        int          wr0;
        x = 8'h00;
        ok = 1'b1;
        wr0 = n_wr;
        legal = (L != 16'd0) && (L <= 16'd2048);
        send_byte(L[7:0]);
        send_byte(L[15:8]);
        if (!legal) begin
            @(negedge w_clk);
            chk("err_len", 32'(w_err), 32'd1);
            chk("prst_len", 32'(w_prst), 32'd1);
            chk("dready_len", 32'(w_dready), 32'd0);
            repeat (3) @(negedge w_clk);
            chk("nwr_len", 32'(n_wr - wr0), 32'd0);
            pay_q.delete();
            return;
        end
        for (int i = 0; i < int'(L); i++) begin
            word = (pay_q.size() > 0) ? pay_q.pop_front() : $urandom;
            exp_q.push_back('{a: 11'(i), d: word});
            for (int k = 0; k < 4; k++) begin
                send_byte(word[8*k +: 8]);
                x = x ^ word[8*k +: 8];
            end
        end
        @(negedge w_clk);
        chk("mwe_last", 32'(w_mwe), 32'd1);
`ifdef LOADER_CSUM_EN
        chk("done_before_csum", 32'(w_done), 32'd0);
        ok = !bad_csum;
        send_byte(bad_csum ? (x ^ 8'h01) : x);
        @(negedge w_clk);
`else
        if (bad_csum) ok = 1'b1;
`endif
        chk("done", 32'(w_done), 32'(ok));
        chk("err", 32'(w_err), 32'(!ok));
        chk("prst_hold", 32'(w_prst), 32'd1);
        @(negedge w_clk);
        chk("prst_rel", 32'(w_prst), 32'(!ok));
        chk("dready_end", 32'(w_dready), 32'd0);
        chk("nwr", 32'(n_wr - wr0), 32'(L));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Reload pulse, optionally with a simultaneous byte that must be ignored.
    task automatic reload(input bit with_byte);
        @(negedge w_clk);
        w_reload = 1'b1;
        if (with_byte) begin
            w_din = 8'h05;
            w_dvalid = 1'b1;
        end
        @(negedge w_clk);
        w_reload = 1'b0;
        w_dvalid = 1'b0;
        chk("rl_err", 32'(w_err), 32'd0);
        chk("rl_done", 32'(w_done), 32'd0);
        chk("rl_prst", 32'(w_prst), 32'd1);
        chk("rl_dready", 32'(w_dready), 32'd1);
    endtask

    initial begin
        logic [31:0] w0;
        repeat (3) @(negedge w_clk);
        chk("rst_mwe", 32'(w_mwe), 32'd0);
        chk("rst_maddr", 32'(w_maddr), 32'd0);
        chk("rst_mdata", w_mdata, 32'd0);
        chk("rst_prst", 32'(w_prst), 32'd1);
        chk("rst_done", 32'(w_done), 32'd0);
        chk("rst_err", 32'(w_err), 32'd0);
        chk("rst_dready", 32'(w_dready), 32'd1);
        w_rst_n = 1'b1;

        // Single word, back-to-back bytes.
        gap_max = 0;
        pay_q.push_back(32'h12345678);
        do_load(16'd1, 1'b0);
        reload(1'b1);

        // Three words with stalls.
        gap_max = 3;
        pay_q.push_back(32'h00000020);
        pay_q.push_back(32'h8C1E0004);
        pay_q.push_back(32'hAC1E0008);
        do_load(16'd3, 1'b0);
        reload(1'b0);

        // Zero length, then recovery.
        do_load(16'd0, 1'b0);
        reload(1'b0);
        pay_q.push_back(32'hDEADBEEF);
        do_load(16'd1, 1'b0);
        reload(1'b0);

        // Oversize length.
        do_load(16'd2049, 1'b0);
        reload(1'b0);

        // Reset in the middle of a 4-word load after 6 payload bytes.
        gap_max = 1;
        w0 = $urandom;
        exp_q.push_back('{a: 11'd0, d: w0});
        send_byte(8'h04);
        send_byte(8'h00);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8]);
        send_byte(8'hA5);
        send_byte(8'h5A);
        @(negedge w_clk);
        w_rst_n = 1'b0;
        #1;
        chk("mid_rst_prst", 32'(w_prst), 32'd1);
        chk("mid_rst_maddr", 32'(w_maddr), 32'd0);
        chk("mid_rst_mwe", 32'(w_mwe), 32'd0);
        chk("mid_rst_sb", 32'(exp_q.size()), 32'd0);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        do_load(16'd1, 1'b0);
        reload(1'b0);

`ifdef LOADER_CSUM_EN
        // Wrong checksum: word still written, load fails.
        pay_q.push_back(32'h12345678);
        do_load(16'd1, 1'b1);
        reload(1'b0);
`endif

        // Randomized loads.
        for (int t = 0; t < 8; t++) begin
            gap_max = $urandom_range(0, 2);
            do_load(16'($urandom_range(1, 5)), ($urandom_range(0, 2) == 0));
            reload($urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge w_clk);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
